// File: rtl/spi_ram_arbiter.sv
// Arbitrates one single-port synchronous RAM between a decoded SPI command stream and a host port.
// Sequences each access (IDLE/ACCESS/WAIT/RESP) and returns read data to whichever side owns it.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int ARB_MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_gnt,
  output logic [7:0]           host_rdata,
  output logic                 host_rvalid,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata,
  output logic                 spi_ovf
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t               state;
  logic                 owner_host;
  logic                 rr_last_host;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [ADDR_SIZE-1:0] spi_addr;
  logic                 pend_valid;
  logic                 pend_we;
  logic [ADDR_SIZE-1:0] pend_addr;
  logic [7:0]           pend_data;
  logic                 spi_data_cmd;
  logic                 grant_spi;
  logic                 grant_host;

  // SPI carries 8 address bits: zero-extend or truncate to the RAM address width
  genvar gi;
  generate
    for (gi = 0; gi < ADDR_SIZE; gi++) begin : g_spi_addr
      if (gi < 8) begin : g_bit
        assign spi_addr[gi] = rx_data[gi];
      end else begin : g_zero
        assign spi_addr[gi] = 1'b0;
      end
    end
  endgenerate

  // rx_data[8] set marks the data commands (01 write, 11 read)
  assign spi_data_cmd = rx_valid && rx_data[8];

  always_comb begin
    grant_spi  = 1'b0;
    grant_host = 1'b0;
    if (state == IDLE) begin
      if (pend_valid && host_req) begin
        if ((ARB_MODE == 1) || rr_last_host) grant_spi = 1'b1;
        else                                 grant_host = 1'b1;
      end else if (pend_valid) begin
        grant_spi = 1'b1;
      end else if (host_req) begin
        grant_host = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner_host   <= 1'b0;
      rr_last_host <= 1'b1;
      wr_addr      <= '0;
      rd_addr      <= '0;
      pend_valid   <= 1'b0;
      pend_we      <= 1'b0;
      pend_addr    <= '0;
      pend_data    <= '0;
      spi_ovf      <= 1'b0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      host_gnt     <= 1'b0;
      host_rdata   <= '0;
      host_rvalid  <= 1'b0;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
    end else begin
      tx_valid    <= 1'b0;
      host_rvalid <= 1'b0;
      host_gnt    <= 1'b0;

      if (rx_valid && (rx_data[9:8] == 2'b00)) wr_addr <= spi_addr;
      if (rx_valid && (rx_data[9:8] == 2'b10)) rd_addr <= spi_addr;

      // A slot released by this cycle's grant may be refilled in the same cycle
      if (grant_spi) pend_valid <= 1'b0;
      if (spi_data_cmd) begin
        if (pend_valid && !grant_spi) begin
          spi_ovf <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_we    <= !rx_data[9];
          pend_addr  <= rx_data[9] ? rd_addr : wr_addr;
          pend_data  <= rx_data[7:0];
        end
      end

      case (state)
        IDLE: begin
          if (grant_spi) begin
            ram_en       <= 1'b1;
            ram_we       <= pend_we;
            ram_addr     <= pend_addr;
            ram_wdata    <= pend_data;
            owner_host   <= 1'b0;
            rr_last_host <= 1'b0;
            state        <= ACCESS;
          end else if (grant_host) begin
            ram_en       <= 1'b1;
            ram_we       <= host_we;
            ram_addr     <= host_addr;
            ram_wdata    <= host_wdata;
            host_gnt     <= 1'b1;
            owner_host   <= 1'b1;
            rr_last_host <= 1'b1;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          state  <= ram_we ? IDLE : WAIT;
        end
        WAIT: begin
          if (owner_host) begin
            host_rdata  <= ram_rdata;
            host_rvalid <= 1'b1;
          end else begin
            tx_data  <= ram_rdata;
            tx_valid <= 1'b1;
          end
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
